// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the word-streamed fabric configuration loader:
// region IDs, FSM states, select-field encodings and the word-count helper.
package fpga_cfg_pkg;

  typedef enum logic [2:0] {
    REG_BRB    = 3'd0,
    REG_BSB    = 3'd1,
    REG_LB     = 3'd2,
    REG_LEFT   = 3'd3,
    REG_RIGHT  = 3'd4,
    REG_TOP    = 3'd5,
    REG_BOTTOM = 3'd6,
    REG_BAD    = 3'd7
  } region_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CRC    = 3'd2,
    COMMIT = 3'd3,
    ERR    = 3'd4
  } state_e;

  // Each 2-bit select field is {bit+1, bit}; an IO entry is {dir[1:0], line[1:0]}
  localparam logic [1:0] DIR_OFF = 2'b00;
  localparam logic [1:0] DIR_IN  = 2'b10;
  localparam logic [1:0] DIR_OUT = 2'b01;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h1021;

  function automatic int words_for(input int bits, input int word_w);
    return (bits + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/cfg_crc16.sv
// CRC-16-CCITT accumulator over whole payload words, each word fed bit 0 first.
// Only instantiated by the loader when CFG_CRC_EN is defined.
module cfg_crc16
  import fpga_cfg_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [WORD_W-1:0] data,
  output logic [15:0]       crc
);

  logic [15:0] crc_next;

  always_comb begin
    crc_next = crc;
    for (int i = 0; i < WORD_W; i++) begin
      if (crc_next[15] ^ data[i])
        crc_next = {crc_next[14:0], 1'b0} ^ CRC_POLY;
      else
        crc_next = {crc_next[14:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      crc <= CRC_INIT;
    else if (clear)
      crc <= CRC_INIT;
    else if (en)
      crc <= crc_next;
  end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Handshaked region loader: fills a shadow register word by word, then commits it atomically
// to the live select outputs. Optional payload CRC check is enabled by defining CFG_CRC_EN.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int WORD_W   = 16,
  parameter int BRB_BITS = 750,
  parameter int BSB_BITS = 1728,
  parameter int LB_BITS  = 80,
  parameter int IO_BITS  = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                cfg_abort,
  output logic                busy,
  output logic                cfg_done,
  output logic                cfg_err,
  output logic [BRB_BITS-1:0] brbselect,
  output logic [BSB_BITS-1:0] bsbselect,
  output logic [LB_BITS-1:0]  lbselect,
  output logic [IO_BITS-1:0]  leftioselect,
  output logic [IO_BITS-1:0]  rightioselect,
  output logic [IO_BITS-1:0]  topioselect,
  output logic [IO_BITS-1:0]  bottomioselect
);

  localparam int MAX_A    = (BRB_BITS > BSB_BITS) ? BRB_BITS : BSB_BITS;
  localparam int MAX_B    = (LB_BITS > IO_BITS) ? LB_BITS : IO_BITS;
  localparam int MAX_BITS = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int SH_WORDS = words_for(MAX_BITS, WORD_W);
  localparam int SH_W     = SH_WORDS * WORD_W;
  localparam int CNT_W    = $clog2(SH_WORDS + 1);

  state_e            state;
  state_e            state_nx;
  region_e           region;
  logic              rdy_en;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  last_idx;
  logic [SH_W-1:0]   shadow;
  logic [SH_W-1:0]   live_sel;
  logic              accept;
  logic              hdr_bad;

  assign accept  = in_valid && in_ready;
  assign hdr_bad = (in_data[2:0] == REG_BAD);

`ifdef CFG_CRC_EN
  logic [15:0] crc;
  logic        crc_ok;

  cfg_crc16 #(.WORD_W(WORD_W)) u_crc (
    .clk   (clk),
    .rst   (rst),
    .clear (state == IDLE),
    .en    (accept && (state == LOAD)),
    .data  (in_data),
    .crc   (crc)
  );

  assign crc_ok = (16'(in_data) == crc);
`endif

  // Index of the final payload word for the region being loaded
  always_comb begin
    last_idx = '0;
    case (region)
      REG_BRB:    last_idx = CNT_W'(words_for(BRB_BITS, WORD_W) - 1);
      REG_BSB:    last_idx = CNT_W'(words_for(BSB_BITS, WORD_W) - 1);
      REG_LB:     last_idx = CNT_W'(words_for(LB_BITS, WORD_W) - 1);
      REG_LEFT,
      REG_RIGHT,
      REG_TOP,
      REG_BOTTOM: last_idx = CNT_W'(words_for(IO_BITS, WORD_W) - 1);
      default:    last_idx = '0;
    endcase
  end

  // Shadow starts from the live value of the region named by the incoming header
  always_comb begin
    live_sel = '0;
    case (region_e'(in_data[2:0]))
      REG_BRB:    live_sel = SH_W'(brbselect);
      REG_BSB:    live_sel = SH_W'(bsbselect);
      REG_LB:     live_sel = SH_W'(lbselect);
      REG_LEFT:   live_sel = SH_W'(leftioselect);
      REG_RIGHT:  live_sel = SH_W'(rightioselect);
      REG_TOP:    live_sel = SH_W'(topioselect);
      REG_BOTTOM: live_sel = SH_W'(bottomioselect);
      default:    live_sel = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:
        if (accept)
          state_nx = hdr_bad ? ERR : LOAD;
      LOAD:
        if (accept && (word_cnt == last_idx))
`ifdef CFG_CRC_EN
          state_nx = CRC;
`else
          state_nx = COMMIT;
`endif
`ifdef CFG_CRC_EN
      CRC:
        if (accept)
          state_nx = crc_ok ? COMMIT : ERR;
`endif
      COMMIT:  state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Abort wins everywhere except the commit cycle, which is already atomic
    if (cfg_abort && (state != COMMIT))
      state_nx = IDLE;
  end

  always_comb begin
    in_ready = rdy_en && !cfg_abort &&
               ((state == IDLE) || (state == LOAD) || (state == CRC));
    busy     = (state != IDLE);
    cfg_done = (state == COMMIT);
  end

  // rdy_en holds in_ready low for the first cycle out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en         <= 1'b0;
      region         <= REG_BRB;
      word_cnt       <= '0;
      shadow         <= '0;
      cfg_err        <= 1'b0;
      brbselect      <= '0;
      bsbselect      <= '0;
      lbselect       <= '0;
      leftioselect   <= '0;
      rightioselect  <= '0;
      topioselect    <= '0;
      bottomioselect <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        case (state)
          IDLE: begin
            region   <= region_e'(in_data[2:0]);
            word_cnt <= '0;
            if (hdr_bad) begin
              cfg_err <= 1'b1;
            end else begin
              cfg_err <= 1'b0;
              shadow  <= live_sel;
            end
          end
          LOAD: begin
            shadow[word_cnt*WORD_W +: WORD_W] <= in_data;
            word_cnt <= word_cnt + 1'b1;
          end
`ifdef CFG_CRC_EN
          CRC:
            if (!crc_ok)
              cfg_err <= 1'b1;
`endif
          default: ;
        endcase
      end
      // Padding bits past the region width in the last word are simply not copied
      if (state == COMMIT) begin
        case (region)
          REG_BRB:    brbselect      <= shadow[BRB_BITS-1:0];
          REG_BSB:    bsbselect      <= shadow[BSB_BITS-1:0];
          REG_LB:     lbselect       <= shadow[LB_BITS-1:0];
          REG_LEFT:   leftioselect   <= shadow[IO_BITS-1:0];
          REG_RIGHT:  rightioselect  <= shadow[IO_BITS-1:0];
          REG_TOP:    topioselect    <= shadow[IO_BITS-1:0];
          REG_BOTTOM: bottomioselect <= shadow[IO_BITS-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed self-checking bench for fpga_cfg_loader; CRC words are appended when CFG_CRC_EN is defined.
module tb_fpga_cfg_loader;

  localparam int WORD_W   = 16;
  localparam int BRB_BITS = 750;
  localparam int BSB_BITS = 1728;
  localparam int LB_BITS  = 80;
  localparam int IO_BITS  = 20;
  localparam int CW       = 1728;

  logic                clk;
  logic                rst;
  logic [WORD_W-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic                cfg_abort;
  logic                busy;
  logic                cfg_done;
  logic                cfg_err;
  logic [BRB_BITS-1:0] brbselect;
  logic [BSB_BITS-1:0] bsbselect;
  logic [LB_BITS-1:0]  lbselect;
  logic [IO_BITS-1:0]  leftioselect;
  logic [IO_BITS-1:0]  rightioselect;
  logic [IO_BITS-1:0]  topioselect;
  logic [IO_BITS-1:0]  bottomioselect;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] tb_crc = 16'hFFFF;
  logic [BRB_BITS-1:0] all_brb;

  fpga_cfg_loader #(
    .WORD_W(WORD_W), .BRB_BITS(BRB_BITS), .BSB_BITS(BSB_BITS),
    .LB_BITS(LB_BITS), .IO_BITS(IO_BITS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .cfg_abort      (cfg_abort),
    .busy           (busy),
    .cfg_done       (cfg_done),
    .cfg_err        (cfg_err),
    .brbselect      (brbselect),
    .bsbselect      (bsbselect),
    .lbselect       (lbselect),
    .leftioselect   (leftioselect),
    .rightioselect  (rightioselect),
    .topioselect    (topioselect),
    .bottomioselect (bottomioselect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no end of run, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  // CRC-16-CCITT, init FFFF, each payload word fed bit 0 first
  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [15:0] w);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 16; i++) begin
      if (r[15] ^ w[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed[63:0]=%h expected[63:0]=%h ones observed=%0d expected=%0d",
             tag, obs[63:0], exp[63:0], $countones(obs), $countones(exp));
    end
  endtask

  // Presents one word for exactly one rising edge, then samples 1 ns later
  task automatic applyStimulus(input logic [15:0] d, input logic is_hdr);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (is_hdr) tb_crc = 16'hFFFF;
    else        tb_crc = crc_model(tb_crc, d);
  endtask

  task automatic closeLoad(input logic [15:0] flip);
`ifdef CFG_CRC_EN
    applyStimulus(tb_crc ^ flip, 1'b0);
`else
    if (flip != 16'h0) $display("[TB] crc flip ignored without CRC build");
`endif
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; cfg_abort = 1'b0;
    all_brb = '1;
    #12;
    checkOutput("rst_in_ready", CW'(in_ready), CW'(1'b0));
    checkOutput("rst_busy",     CW'(busy),     CW'(1'b0));
    checkOutput("rst_done",     CW'(cfg_done), CW'(1'b0));
    checkOutput("rst_err",      CW'(cfg_err),  CW'(1'b0));
    checkOutput("rst_bsb",      CW'(bsbselect), CW'(0));
    rst = 1'b0;
    #1;
    checkOutput("rel_in_ready_low", CW'(in_ready), CW'(1'b0));
    @(posedge clk); #1;
    checkOutput("rel_in_ready_high", CW'(in_ready), CW'(1'b1));

    // 1: bottom IO, 2 words
    applyStimulus(16'h0006, 1'b1);
    checkOutput("t1_busy", CW'(busy), CW'(1'b1));
    applyStimulus(16'h0008, 1'b0);
    applyStimulus(16'h0000, 1'b0);
    closeLoad(16'h0);
    checkOutput("t1_done",      CW'(cfg_done),       CW'(1'b1));
    checkOutput("t1_ready_low", CW'(in_ready),       CW'(1'b0));
    checkOutput("t1_not_yet",   CW'(bottomioselect), CW'(0));
    @(posedge clk); #1;
    checkOutput("t1_bottom",    CW'(bottomioselect), CW'(20'h00008));
    checkOutput("t1_done_once", CW'(cfg_done),       CW'(1'b0));
    checkOutput("t1_idle",      CW'(busy),           CW'(1'b0));

    // 2: BRB, 47 words of ones, top two bits of the last word dropped
    applyStimulus(16'h0000, 1'b1);
    for (int i = 0; i < 46; i++) applyStimulus(16'hFFFF, 1'b0);
    checkOutput("t2_still_busy", CW'(busy),      CW'(1'b1));
    checkOutput("t2_no_early",   CW'(cfg_done),  CW'(1'b0));
    checkOutput("t2_brb_hold",   CW'(brbselect), CW'(0));
    applyStimulus(16'hFFFF, 1'b0);
    closeLoad(16'h0);
    checkOutput("t2_done", CW'(cfg_done), CW'(1'b1));
    @(posedge clk); #1;
    checkOutput("t2_brb",    CW'(brbselect),      CW'(all_brb));
    checkOutput("t2_bottom", CW'(bottomioselect), CW'(20'h00008));
    checkOutput("t2_bsb",    CW'(bsbselect),      CW'(0));
    checkOutput("t2_lb",     CW'(lbselect),       CW'(0));

    // 3: bad region header, then a good header clears the error
    applyStimulus(16'h0007, 1'b1);
    checkOutput("t3_err",       CW'(cfg_err),   CW'(1'b1));
    checkOutput("t3_ready_low", CW'(in_ready),  CW'(1'b0));
    checkOutput("t3_brb_kept",  CW'(brbselect), CW'(all_brb));
    @(posedge clk); #1;
    checkOutput("t3_ready_back", CW'(in_ready), CW'(1'b1));
    checkOutput("t3_err_sticky", CW'(cfg_err),  CW'(1'b1));
    applyStimulus(16'h0002, 1'b1);
    checkOutput("t3_err_clear", CW'(cfg_err), CW'(1'b0));
    applyStimulus(16'h001F, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(16'h0000, 1'b0);
    closeLoad(16'h0);
    @(posedge clk); #1;
    checkOutput("t3_lb", CW'(lbselect), CW'(80'h1F));

    // 4: BSB aborted after 50 of 108 words, abort coinciding with a valid word
    applyStimulus(16'h0001, 1'b1);
    for (int i = 0; i < 50; i++) applyStimulus(16'hAAAA, 1'b0);
    in_data = 16'h1234; in_valid = 1'b1; cfg_abort = 1'b1;
    #1;
    checkOutput("t4_ready_abort", CW'(in_ready), CW'(1'b0));
    @(posedge clk); #1;
    checkOutput("t4_busy",    CW'(busy),      CW'(1'b0));
    checkOutput("t4_no_done", CW'(cfg_done),  CW'(1'b0));
    checkOutput("t4_bsb",     CW'(bsbselect), CW'(0));
    cfg_abort = 1'b0; in_valid = 1'b0;
    #1;
    checkOutput("t4_ready_back", CW'(in_ready), CW'(1'b1));
    applyStimulus(16'h0004, 1'b1);
    applyStimulus(16'h0003, 1'b0);
    applyStimulus(16'h0000, 1'b0);
    closeLoad(16'h0);
    @(posedge clk); #1;
    checkOutput("t4_right", CW'(rightioselect), CW'(20'h00003));
    checkOutput("t4_bsb_after", CW'(bsbselect), CW'(0));

    // 5: async reset in the middle of an LB load
    applyStimulus(16'h0002, 1'b1);
    applyStimulus(16'h0001, 1'b0);
    applyStimulus(16'h0002, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("t5_lb",     CW'(lbselect),       CW'(0));
    checkOutput("t5_brb",    CW'(brbselect),      CW'(0));
    checkOutput("t5_bottom", CW'(bottomioselect), CW'(0));
    checkOutput("t5_right",  CW'(rightioselect),  CW'(0));
    checkOutput("t5_busy",   CW'(busy),           CW'(1'b0));
    checkOutput("t5_ready",  CW'(in_ready),       CW'(1'b0));
    #3;
    rst = 1'b0;
    #1;
    checkOutput("t5_ready_first", CW'(in_ready), CW'(1'b0));
    @(posedge clk); #1;
    checkOutput("t5_ready_after", CW'(in_ready), CW'(1'b1));

`ifdef CFG_CRC_EN
    // 6: correct CRC commits, corrupted CRC errors without commit
    applyStimulus(16'h0002, 1'b1);
    applyStimulus(16'h00F0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(16'h0000, 1'b0);
    closeLoad(16'h0);
    checkOutput("t6_done", CW'(cfg_done), CW'(1'b1));
    @(posedge clk); #1;
    checkOutput("t6_lb", CW'(lbselect), CW'(80'hF0));
    applyStimulus(16'h0002, 1'b1);
    applyStimulus(16'h0F00, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(16'h0000, 1'b0);
    closeLoad(16'h1);
    checkOutput("t6_bad_err",     CW'(cfg_err),  CW'(1'b1));
    checkOutput("t6_bad_no_done", CW'(cfg_done), CW'(1'b0));
    @(posedge clk); #1;
    checkOutput("t6_bad_lb",   CW'(lbselect), CW'(80'hF0));
    checkOutput("t6_bad_done", CW'(cfg_done), CW'(1'b0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
